uart_tx_param: RTL

Parametrised UART transmitter: the successor to the fixed 12 MHz / 9600 baud / 8N1 transmitter. It adds a configurable clock/baud divisor, data width and stop-bit count, and a small input FIFO behind a valid/ready handshake, so callers can queue bytes without polling `busy`. It sits between the byte-producing logic and the `tx` pin.

---
 rtl/uart_tx_param.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a small input FIFO.
// Ports: clk; nrst (async, active low); data_in/data_valid/data_ready push
// handshake into the FIFO; tx serial line (registered, idles high); busy
// (FIFO non-empty or frame in flight); tx_done one-cycle pulse on the last
// stop-bit clock; fifo_count FIFO occupancy.
// Optional parity bit after the data: define UART_TX_PARITY_EN.
module uart_tx_param #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       ODD      = 1'(PARITY_ODD);
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              tick;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign push       = data_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign data_ready = !full;
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = !empty || (state_q != S_IDLE);
  assign tick       = (baud_q == BAUD_LAST);
  assign tx_done    = (state_q == S_STOP) && tick
                   && (bit_q == STOP_LAST);

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = (^head) ^ ODD;
`endif
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 1'b1;
          end else if (!empty) begin
            // Chain straight into the next start bit.
            pop     = 1'b1;
            shreg_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = (^head) ^ ODD;
`endif
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
